// File: rtl/network_sequencer.sv
// rtl/network_sequencer.sv - sequences one stochastic network evaluation per request.
// Optional abort input enabled by defining NETSEQ_ABORT_EN.
module network_sequencer #(
  parameter int INPUT_SIZE   = 2,
  parameter int OUTPUT_SIZE  = 1,
  parameter int WINDOW       = 256,
  parameter int FLUSH_CYCLES = 4,
  parameter int CAPTURE_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef NETSEQ_ABORT_EN
  input  logic                      abort,
`endif
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [INPUT_SIZE*32-1:0]  req_data,
  output logic [INPUT_SIZE*32-1:0]  net_input,
  output logic                      net_n_rst,
  output logic                      net_compute,
  input  logic [OUTPUT_SIZE*32-1:0] net_output,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [OUTPUT_SIZE*32-1:0] rsp_data,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_CAPTURE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] RUN_LAST   = 16'(WINDOW - 1);
  localparam logic [15:0] WAIT_LAST  = 16'((CAPTURE_LAT > 0) ? CAPTURE_LAT - 1 : 0);
  localparam bit          HAS_WAIT   = (CAPTURE_LAT > 0);

  state_t                    state, state_nx;
  logic [15:0]               cnt, cnt_nx;
  logic [INPUT_SIZE*32-1:0]  input_q;
  logic [OUTPUT_SIZE*32-1:0] data_q;
  logic                      accept;
  logic                      sample;
  logic                      abort_hit;

`ifdef NETSEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    accept      = 1'b0;
    sample      = 1'b0;
    req_ready   = 1'b0;
    net_n_rst   = 1'b1;
    net_compute = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        net_n_rst = 1'b0;
        if (req_valid) begin
          accept   = 1'b1;
          cnt_nx   = 16'd0;
          state_nx = S_FLUSH;
        end
      end
      S_FLUSH: begin
        net_n_rst = 1'b0;
        if (cnt == FLUSH_LAST) begin
          cnt_nx   = 16'd0;
          state_nx = S_RUN;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_RUN: begin
        if (cnt == RUN_LAST) begin
          cnt_nx   = 16'd0;
          state_nx = S_CAPTURE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_CAPTURE: begin
        net_compute = 1'b1;
        cnt_nx      = 16'd0;
        if (HAS_WAIT) begin
          state_nx = S_WAIT;
        end else begin
          sample   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_WAIT: begin
        // Outputs are valid on the last latency cycle, so sample as we leave.
        if (cnt == WAIT_LAST) begin
          sample   = 1'b1;
          cnt_nx   = 16'd0;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 16'd0;
      end
    endcase

    // Abort wins over any phase-end transition taken above.
    if (abort_hit && (state == S_FLUSH || state == S_RUN ||
                      state == S_CAPTURE || state == S_WAIT)) begin
      state_nx = S_IDLE;
      cnt_nx   = 16'd0;
      sample   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 16'd0;
      input_q <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        input_q <= req_data;
      end
      if (sample) begin
        data_q <= net_output;
      end
    end
  end

  assign net_input = input_q;
  assign rsp_data  = data_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/network_sequencer.md
Name: network_sequencer

Overview:
Controller that sequences one stochastic network evaluation per request.
- Accepts an input vector over a valid/ready handshake and holds it stable on the network inputs.
- Flushes the network state, runs the bitstream for a fixed window, then pulses the network's compute/capture.
- Samples the integrated outputs and returns them over a valid/ready handshake. Sits between the host/test driver and the bitstream network instance.

Parameters:
- INPUT_SIZE, 2, number of network inputs (32-bit each)
- OUTPUT_SIZE, 1, number of network outputs (32-bit each)
- WINDOW, 256, bitstream cycles per evaluation; legal range 1..65535
- FLUSH_CYCLES, 4, cycles net_n_rst is held low before a run; legal range 1..255
- CAPTURE_LAT, 1, cycles from net_compute pulse to valid network outputs; legal range 0..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request vector valid
- req_ready  out  1  sequencer accepts request
- req_data  in  INPUT_SIZE*32  input vector; element i at [i*32+:32]
- net_input  out  INPUT_SIZE*32  held vector driven to network inputs
- net_n_rst  out  1  active-low reset to network generators/layers/integrators
- net_compute  out  1  one-cycle capture pulse to network integrators
- net_output  in  OUTPUT_SIZE*32  network integrator outputs
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  OUTPUT_SIZE*32  captured result vector
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; req_ready=1, rsp_valid=0, net_compute=0, net_n_rst=0, busy=0.
  - net_input=0 and rsp_data=0; all counters=0.
  - Reset mid-operation discards the in-flight request and any unconsumed result.
- States: IDLE, FLUSH, RUN, CAPTURE, WAIT, DONE.
- IDLE:
  - req_ready=1; net_n_rst=0.
  - On req_valid&&req_ready: latch req_data into net_input, counter=0, go to FLUSH.
- FLUSH: net_n_rst=0 for exactly FLUSH_CYCLES cycles, then go to RUN with counter=0.
- RUN: net_n_rst=1 for exactly WINDOW cycles, then go to CAPTURE.
- CAPTURE:
  - One cycle with net_compute=1 and net_n_rst=1.
  - Go to WAIT if CAPTURE_LAT>0, else sample net_output into rsp_data and go to DONE.
- WAIT: CAPTURE_LAT cycles with net_n_rst=1, then sample net_output into rsp_data on the last WAIT cycle and go to DONE.
- DONE:
  - rsp_valid=1; rsp_data stable until the handshake completes.
  - net_n_rst=1, so the network holds its captured value.
  - On rsp_valid&&rsp_ready: rsp_valid=0 on the next cycle, go to IDLE.
- Handshake and timing:
  - req_ready is 1 only in IDLE. A new request cannot be accepted on the cycle the response completes; the earliest acceptance is the following cycle.
  - net_input changes only on request acceptance; it holds its value through IDLE after completion.
  - net_compute is high in the CAPTURE state only; never two consecutive cycles.
  - Latency from acceptance edge to rsp_valid=1: FLUSH_CYCLES+WINDOW+1+CAPTURE_LAT cycles.
- Counter: 16-bit, compared against (param-1); no wrap inside a phase.
- rsp_ready held high before DONE has no effect.
- req_valid deasserted before acceptance: no action.

Optional Feature:
NETSEQ_ABORT_EN
- With the macro defined, an extra input port abort (1 bit) is added.
  - abort=1 in FLUSH, RUN, CAPTURE or WAIT: go to IDLE next cycle. No response is produced; rsp_valid stays 0 and net_n_rst=0.
  - abort in IDLE or DONE is ignored.
  - abort has priority over phase-end transitions in the same cycle.
- Without the macro the port does not exist and evaluations always complete.

Test Plan:
- Reset, then req_data={130,172} pulsed valid for 1 cycle; default params:
  - net_n_rst low for 4 cycles, high 256 cycles.
  - net_compute high exactly 1 cycle.
  - rsp_valid rises 262 cycles after acceptance; rsp_data equals net_output sampled 1 cycle after the compute pulse.
- Backpressure: rsp_ready=0 for 20 cycles in DONE, with net_output toggled by the bench.
  - rsp_data and rsp_valid stay stable; req_ready=0 throughout.
  - Completes on the rsp_ready=1 cycle; req_ready=1 the next cycle.
- Back-to-back: req_valid held high with two vectors, rsp_ready=1.
  - Second acceptance occurs 1 cycle after the first response completes.
  - net_input switches only at the second acceptance.
- Reset mid-RUN (cycle 100 of window):
  - Next cycle: IDLE, net_n_rst=0, rsp_valid=0, net_input=0.
  - A fresh request then completes with full latency.
- Params WINDOW=1, FLUSH_CYCLES=1, CAPTURE_LAT=0:
  - Latency 3 cycles.
  - rsp_data is captured in the CAPTURE cycle.
- NETSEQ_ABORT_EN defined, abort asserted in RUN on the same cycle the window ends:
  - Returns to IDLE; no net_compute pulse; no rsp_valid.
  - abort asserted in DONE is ignored.
